// File: rtl/router_pkg.sv
// Shared router definitions: header address width, FSM state set, decoded
// control-strobe bundle and small helpers used by the router control blocks.
package router_pkg;

   localparam int                ADDR_W       = 2;
   localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
   localparam int                NUM_FIFOS    = 3;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      WAIT_TILL_EMPTY    = 4'd1,
      LOAD_FIRST_DATA    = 4'd2,
      LOAD_DATA          = 4'd3,
      FIFO_FULL_STATE    = 4'd4,
      LOAD_AFTER_FULL    = 4'd5,
      LOAD_PARITY        = 4'd6,
      CHECK_PARITY_ERROR = 4'd7
   } state_t;

   typedef struct packed {
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
      logic rst_int_reg;
      logic write_enb_reg;
      logic busy;
   } fsm_out_t;

   // Moore decode: the strobe set that belongs to a state.
   function automatic fsm_out_t decode_state(state_t s);
      fsm_out_t o;
      o      = '0;
      o.busy = 1'b1;
      case (s)
         DECODE_ADDRESS: begin
            o.detect_add = 1'b1;
            o.busy       = 1'b0;
         end
         LOAD_FIRST_DATA: o.lfd_state = 1'b1;
         LOAD_DATA: begin
            o.ld_state      = 1'b1;
            o.write_enb_reg = 1'b1;
            o.busy          = 1'b0;
         end
         FIFO_FULL_STATE: o.full_state = 1'b1;
         LOAD_AFTER_FULL: begin
            o.laf_state     = 1'b1;
            o.write_enb_reg = 1'b1;
         end
         LOAD_PARITY:        o.write_enb_reg = 1'b1;
         CHECK_PARITY_ERROR: o.rst_int_reg   = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   // Per-FIFO flag picked by address; addresses with no FIFO read as 0.
   function automatic logic fifo_flag(logic [NUM_FIFOS-1:0] flags,
                                      logic [ADDR_W-1:0]    addr);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (addr == ADDR_W'(i)) r = flags[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM (slave) and the datapath blocks
// that feed it status and consume its strobes (master).
interface router_fsm_if
   import router_pkg::*;
();
   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic              empty_0, empty_1, empty_2;
   logic              soft_reset_0, soft_reset_1, soft_reset_2;
   logic              parity_done;
   logic              low_pkt_valid;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              rst_int_reg;
   logic              write_enb_reg;
   logic              busy;
   logic [ADDR_W-1:0] addr_q;

   modport master (
      output pkt_valid, data_in, fifo_full, empty_0, empty_1, empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, addr_q
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, empty_0, empty_1, empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, addr_q
   );
endinterface

// File: rtl/router_fsm.sv
// 1x3 router control FSM: header decode, payload load, full stall and parity
// sequencing. Strobes are registered from the next state so they stay glitch-free.
module router_fsm
   import router_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   router_fsm_if.slave bus
);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   fsm_out_t             out_q;
   logic [NUM_FIFOS-1:0] empty_vec, soft_vec;
   logic [ADDR_W-1:0]    sel_addr;
   logic                 empty_sel, soft_sel, hdr_ok;

   assign empty_vec = {bus.empty_2, bus.empty_1, bus.empty_0};
   assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
   assign hdr_ok    = bus.pkt_valid && (bus.data_in != INVALID_ADDR);

   // The header is still on data_in while decoding; afterwards the latched address rules.
   assign sel_addr  = (state_q == DECODE_ADDRESS) ? bus.data_in : addr_q;
   assign empty_sel = fifo_flag(empty_vec, sel_addr);
   assign soft_sel  = fifo_flag(soft_vec, sel_addr);

   always_comb begin
      // NOTE: defaults first so every path assigns state_d/addr_d -- no inferred latch.
      state_d = state_q;
      addr_d  = addr_q;

      if (state_q != DECODE_ADDRESS && soft_sel) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (hdr_ok) state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: if (empty_sel) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (bus.fifo_full)      state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)        state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default: state_d = DECODE_ADDRESS;
         endcase
      end

      if (state_q == DECODE_ADDRESS && hdr_ok) addr_d = bus.data_in;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
         out_q   <= decode_state(DECODE_ADDRESS);
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
         state_q <= state_d;
         addr_q  <= addr_d;
         out_q   <= decode_state(state_d);
      end
   end

   assign bus.detect_add    = out_q.detect_add;
   assign bus.lfd_state     = out_q.lfd_state;
   assign bus.ld_state      = out_q.ld_state;
   assign bus.laf_state     = out_q.laf_state;
   assign bus.full_state    = out_q.full_state;
   assign bus.rst_int_reg   = out_q.rst_int_reg;
   assign bus.write_enb_reg = out_q.write_enb_reg;
   assign bus.busy          = out_q.busy;
   assign bus.addr_q        = addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios plus a randomized run
// against a phase-level reference model of the packet sequencing rules.
module tb_router_fsm;
   import router_pkg::*;

   logic clock = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_bad = 0;

   router_fsm_if bus();
   router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));

   always #5 clock = ~clock;

   // Expected strobes, packed {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}.
   localparam logic [7:0] O_DEC  = 8'b1000_0000;
   localparam logic [7:0] O_WAIT = 8'b0000_0001;
   localparam logic [7:0] O_LFD  = 8'b0100_0001;
   localparam logic [7:0] O_LD   = 8'b0010_0010;
   localparam logic [7:0] O_FULL = 8'b0000_1001;
   localparam logic [7:0] O_LAF  = 8'b0001_0011;
   localparam logic [7:0] O_LP   = 8'b0000_0011;
   localparam logic [7:0] O_CPE  = 8'b0000_0101;

   typedef enum int {M_IDLE, M_WAIT, M_FIRST, M_BODY, M_STALL, M_RESUME, M_PARITY, M_CHECK} phase_t;

   function automatic logic [7:0] obs_vec();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
   endfunction

   function automatic logic [7:0] phase_out(phase_t p);
      case (p)
         M_IDLE:   return O_DEC;
         M_WAIT:   return O_WAIT;
         M_FIRST:  return O_LFD;
         M_BODY:   return O_LD;
         M_STALL:  return O_FULL;
         M_RESUME: return O_LAF;
         M_PARITY: return O_LP;
         default:  return O_CPE;
      endcase
   endfunction

   // Packet-sequencing rules: which phase follows given the sampled inputs.
   function automatic phase_t model_next(phase_t p, bit pv, bit [1:0] din, bit [1:0] a,
                                         bit [2:0] emp, bit [2:0] sr, bit ff, bit pd, bit lpv);
      bit [3:0] emp4 = {1'b0, emp};
      bit [3:0] sr4  = {1'b0, sr};
      bit [1:0] idx  = (p == M_IDLE) ? din : a;
      if (p != M_IDLE && sr4[idx]) return M_IDLE;
      case (p)
         M_IDLE:   return (pv && din != 2'd3) ? (emp4[idx] ? M_FIRST : M_WAIT) : M_IDLE;
         M_WAIT:   return emp4[idx] ? M_FIRST : M_WAIT;
         M_FIRST:  return M_BODY;
         M_BODY:   return ff ? M_STALL : (!pv ? M_PARITY : M_BODY);
         M_STALL:  return ff ? M_STALL : M_RESUME;
         M_RESUME: return pd ? M_IDLE : (lpv ? M_PARITY : M_BODY);
         M_PARITY: return M_CHECK;
         default:  return ff ? M_STALL : M_IDLE;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pkt_valid     = 1'b0;
      bus.data_in       = '0;
      bus.fifo_full     = 1'b0;
      bus.empty_0       = 1'b1;
      bus.empty_1       = 1'b1;
      bus.empty_2       = 1'b1;
      bus.soft_reset_0  = 1'b0;
      bus.soft_reset_1  = 1'b0;
      bus.soft_reset_2  = 1'b0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      idle_inputs();
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== O_DEC) begin
         n_bad++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), O_DEC);
      end
      n_cmp++;
      if (bus.addr_q !== 2'b00) begin
         n_bad++; $display("FAIL reset_addr: got %b expected 00", bus.addr_q);
      end
      tick();
      resetn = 1'b1;
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b10;
      tick();
      tick();
      n_cmp++;
      if (obs_vec() !== O_LD) begin
         n_bad++; $display("FAIL reset_reach_ld: got %b expected %b", obs_vec(), O_LD);
      end
      resetn = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== O_DEC) begin
         n_bad++; $display("FAIL reset_mid_packet: got %b expected %b", obs_vec(), O_DEC);
      end
      n_cmp++;
      if (bus.addr_q !== 2'b00) begin
         n_bad++; $display("FAIL reset_mid_addr: got %b expected 00", bus.addr_q);
      end
      idle_inputs();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_normal_packet();
      logic [7:0] exp_seq [5] = '{O_LFD, O_LD, O_LD, O_LP, O_CPE};
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b01;
      bus.empty_1   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 2) bus.pkt_valid = 1'b0;
         n_cmp++;
         if (obs_vec() !== exp_seq[i]) begin
            n_bad++; $display("FAIL normal_step%0d: got %b expected %b", i, obs_vec(), exp_seq[i]);
         end
      end
      tick();
      n_cmp++;
      if (obs_vec() !== O_DEC) begin
         n_bad++; $display("FAIL normal_done: got %b expected %b", obs_vec(), O_DEC);
      end
      n_cmp++;
      if (bus.addr_q !== 2'b01) begin
         n_bad++; $display("FAIL normal_addr: got %b expected 01", bus.addr_q);
      end
   endtask

   task automatic test_invalid_addr();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b11;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== O_DEC || bus.addr_q !== 2'b01) begin
            n_bad++; $display("FAIL invalid_addr%0d: got %b/%b expected %b/01", i, obs_vec(), bus.addr_q, O_DEC);
         end
      end
   endtask

   task automatic test_busy_target();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b10;
      bus.empty_2   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== O_WAIT || bus.addr_q !== 2'b10) begin
            n_bad++; $display("FAIL busy_wait%0d: got %b/%b expected %b/10", i, obs_vec(), bus.addr_q, O_WAIT);
         end
      end
      bus.empty_2 = 1'b1;
      tick();
      n_cmp++;
      if (obs_vec() !== O_LFD) begin
         n_bad++; $display("FAIL busy_release: got %b expected %b", obs_vec(), O_LFD);
      end
      tick();
      n_cmp++;
      if (obs_vec() !== O_LD) begin
         n_bad++; $display("FAIL busy_to_ld: got %b expected %b", obs_vec(), O_LD);
      end
   endtask

   task automatic test_full_stall();
      logic [7:0] exp_seq [4] = '{O_LAF, O_LP, O_CPE, O_DEC};
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (obs_vec() !== O_FULL) begin
            n_bad++; $display("FAIL full_stall%0d: got %b expected %b", i, obs_vec(), O_FULL);
         end
      end
      bus.fifo_full     = 1'b0;
      bus.pkt_valid     = 1'b0;
      bus.low_pkt_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 1) bus.low_pkt_valid = 1'b0;
         n_cmp++;
         if (obs_vec() !== exp_seq[i]) begin
            n_bad++; $display("FAIL full_resume%0d: got %b expected %b", i, obs_vec(), exp_seq[i]);
         end
      end
      // Second packet: resume with parity already captured returns straight to decode.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b00;
      tick();
      tick();
      bus.fifo_full = 1'b1;
      tick();
      bus.fifo_full   = 1'b0;
      bus.parity_done = 1'b1;
      tick();
      n_cmp++;
      if (obs_vec() !== O_LAF) begin
         n_bad++; $display("FAIL parity_done_laf: got %b expected %b", obs_vec(), O_LAF);
      end
      bus.pkt_valid = 1'b0;
      tick();
      n_cmp++;
      if (obs_vec() !== O_DEC) begin
         n_bad++; $display("FAIL parity_done_exit: got %b expected %b", obs_vec(), O_DEC);
      end
      bus.parity_done = 1'b0;
   endtask

   task automatic test_soft_reset();
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'b00;
      bus.empty_0   = 1'b0;
      tick();
      n_cmp++;
      if (obs_vec() !== O_WAIT || bus.addr_q !== 2'b00) begin
         n_bad++; $display("FAIL soft_wait: got %b/%b expected %b/00", obs_vec(), bus.addr_q, O_WAIT);
      end
      bus.soft_reset_1 = 1'b1;
      tick();
      n_cmp++;
      if (obs_vec() !== O_WAIT) begin
         n_bad++; $display("FAIL soft_other_fifo: got %b expected %b", obs_vec(), O_WAIT);
      end
      bus.soft_reset_1 = 1'b0;
      bus.soft_reset_0 = 1'b1;
      bus.pkt_valid    = 1'b0;
      tick();
      n_cmp++;
      if (obs_vec() !== O_DEC) begin
         n_bad++; $display("FAIL soft_own_fifo: got %b expected %b", obs_vec(), O_DEC);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      phase_t   ph, nph;
      bit [1:0] a, na;
      bit [2:0] emp, sr;
      resetn = 1'b0;
      idle_inputs();
      tick();
      resetn = 1'b1;
      ph = M_IDLE;
      a  = 2'b00;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         bus.pkt_valid     = ($urandom % 4) != 0;
         bus.data_in       = 2'($urandom % 4);
         emp               = 3'($urandom % 8);
         sr                = {($urandom % 24) == 0, ($urandom % 24) == 0, ($urandom % 24) == 0};
         bus.empty_0       = emp[0];
         bus.empty_1       = emp[1];
         bus.empty_2       = emp[2];
         bus.soft_reset_0  = sr[0];
         bus.soft_reset_1  = sr[1];
         bus.soft_reset_2  = sr[2];
         bus.fifo_full     = ($urandom % 3) == 0;
         bus.parity_done   = ($urandom % 8) == 0;
         bus.low_pkt_valid = ($urandom % 4) == 0;
         nph = model_next(ph, bus.pkt_valid, bus.data_in, a, emp, sr,
                          bus.fifo_full, bus.parity_done, bus.low_pkt_valid);
         na  = (ph == M_IDLE && bus.pkt_valid && bus.data_in != 2'd3) ? bus.data_in : a;
         tick();
         ph = nph;
         a  = na;
         n_cmp++;
         if (obs_vec() !== phase_out(ph)) begin
            n_bad++; $display("FAIL rand_out cyc%0d: got %b expected %b", cyc, obs_vec(), phase_out(ph));
         end
         n_cmp++;
         if (bus.addr_q !== a) begin
            n_bad++; $display("FAIL rand_addr cyc%0d: got %b expected %b", cyc, bus.addr_q, a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_packet();
      test_invalid_addr();
      test_busy_target();
      test_full_stall();
      test_soft_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
